// File: rtl/des_key_seq.sv
// des_key_seq: iterative DES key schedule. One 56-bit C/D register, a
// 1-or-2 bit rotator per half and a single PC-2 network produce the 16
// round subkeys one per handshake, K1..K16 (encrypt) or K16..K1 (decrypt).
// Bit numbering: key[63] is DES bit 1, cd[55] is C bit 1, subkey[47] is K bit 1.
module des_key_seq #(
  parameter logic [15:0] SHIFT2_MASK = 16'h7EFC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key,
  input  logic        decrypt,
  input  logic        abort,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  subkey_round,
  output logic        subkey_last
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high. valid never depends on ready, and once raised it stays high
  // with stable data until that transfer (or an abort/reset) occurs.

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nx;
  logic [55:0] cd, cd_nx;
  logic [3:0]  count, count_nx;
  logic        dir, dir_nx;
  logic [3:0]  enc_idx;
  logic [3:0]  dec_idx;

  // PC-1: key bit positions 57,49,..,36 (C) then 63,55,..,4 (D), as vector indices 64-p.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    return {k[7],  k[15], k[23], k[31], k[39], k[47], k[55], k[63],
            k[6],  k[14], k[22], k[30], k[38], k[46], k[54], k[62],
            k[5],  k[13], k[21], k[29], k[37], k[45], k[53], k[61],
            k[4],  k[12], k[20], k[28],
            k[1],  k[9],  k[17], k[25], k[33], k[41], k[49], k[57],
            k[2],  k[10], k[18], k[26], k[34], k[42], k[50], k[58],
            k[3],  k[11], k[19], k[27], k[35], k[43], k[51], k[59],
            k[36], k[44], k[52], k[60]};
  endfunction

  // PC-2: C/D bit positions 14,17,..,32, as vector indices 56-p.
  function automatic logic [47:0] pc2(input logic [55:0] c);
    return {c[42], c[39], c[45], c[32], c[55], c[51], c[53], c[28],
            c[41], c[50], c[35], c[46], c[33], c[37], c[44], c[52],
            c[30], c[48], c[40], c[49], c[29], c[36], c[43], c[54],
            c[15], c[4],  c[25], c[19], c[9],  c[1],  c[26], c[16],
            c[5],  c[11], c[23], c[8],  c[12], c[7],  c[17], c[0],
            c[22], c[3],  c[10], c[14], c[6],  c[20], c[27], c[24]};
  endfunction

  // Left rotation of C and D independently (28-bit wrap), by 2 when two is set.
  function automatic logic [55:0] rotl(input logic [55:0] c, input logic two);
    return two ? {c[53:28], c[55:54], c[25:0], c[27:26]}
               : {c[54:28], c[55],    c[26:0], c[27]};
  endfunction

  // Right rotation of C and D independently, used to walk the schedule backwards.
  function automatic logic [55:0] rotr(input logic [55:0] c, input logic two);
    return two ? {c[29:28], c[55:30], c[1:0], c[27:2]}
               : {c[28],    c[55:29], c[0],   c[27:1]};
  endfunction

  // Encrypt walks forward: the next round is count+2, whose mask bit is count+1.
  // Decrypt walks back from the current round 16-count, mask bit 15-count.
  assign enc_idx = count + 4'd1;
  assign dec_idx = 4'd15 - count;

  // Registered state; reset also clears the C/D register so subkey reads 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cd    <= '0;
      count <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_nx;
      cd    <= cd_nx;
      count <= count_nx;
      dir   <= dir_nx;
    end
  end

  // Next-state: key load in IDLE, rotate-and-count per subkey handshake in RUN.
  always_comb begin
    state_nx = state;
    cd_nx    = cd;
    count_nx = count;
    dir_nx   = dir;
    if (abort) begin
      state_nx = IDLE;
      count_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            // Decrypt starts at C16/D16, which equals C0/D0 after 28 rotations.
            cd_nx    = decrypt ? pc1(key) : rotl(pc1(key), SHIFT2_MASK[0]);
            dir_nx   = decrypt;
            count_nx = '0;
            state_nx = RUN;
          end
        end
        RUN: begin
          if (subkey_ready) begin
            count_nx = count + 4'd1;
            if (count == 4'd15) begin
              state_nx = IDLE;
            end else if (dir) begin
              cd_nx = rotr(cd, SHIFT2_MASK[dec_idx]);
            end else begin
              cd_nx = rotl(cd, SHIFT2_MASK[enc_idx]);
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Outputs depend only on registers.
  always_comb begin
    key_ready    = (state == IDLE);
    subkey_valid = (state == RUN);
    subkey       = pc2(cd);
    subkey_round = dir ? (4'd15 - count) : count;
    subkey_last  = (state == RUN) && (count == 4'd15);
  end

endmodule

// File: tb/tb_des_key_seq.sv
// tb_des_key_seq: randomized bench for des_key_seq with an unrolled
// key-schedule reference model and an expected-subkey queue.
module tb_des_key_seq;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key;
  logic        decrypt;
  logic        abort;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic [3:0]  subkey_round;
  logic        subkey_last;

  des_key_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key          (key),
    .decrypt      (decrypt),
    .abort        (abort),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .subkey_round (subkey_round),
    .subkey_last  (subkey_last)
  );

  // FIPS 46-3 tables, 1-based bit numbers.
  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] FIPS_K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] FIPS_K2  = 48'h79AED9DBC9E5;
  localparam logic [47:0] FIPS_K16 = 48'hCB3D8B0E17F5;

  int n_checks;
  int n_pass;
  int seq_cycles;
  logic [47:0] ref_ks [16];
  logic [47:0] got_ks [16];
  logic [52:0] exp_q [$];   // {last, round, subkey}

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: every round key computed directly from C0/D0 and the
  // cumulative rotation count, as the unrolled schedule would.
  task automatic model_schedule(input logic [63:0] k);
    int kb [1:64];
    int cd0 [1:56];
    int cdr [1:56];
    int s;
    for (int i = 1; i <= 64; i++) kb[i] = int'(k[64-i]);
    for (int i = 1; i <= 56; i++) cd0[i] = kb[PC1_T[i-1]];
    s = 0;
    for (int r = 1; r <= 16; r++) begin
      s += SHIFTS[r-1];
      for (int i = 1; i <= 28; i++) begin
        cdr[i]    = cd0[((i - 1 + s) % 28) + 1];
        cdr[28+i] = cd0[28 + ((i - 1 + s) % 28) + 1];
      end
      for (int j = 1; j <= 48; j++) ref_ks[r-1][48-j] = 1'(cdr[PC2_T[j-1]]);
    end
  endtask

  task automatic build_exp(input logic [63:0] k, input logic dec);
    int rnd;
    model_schedule(k);
    exp_q.delete();
    for (int n = 0; n < 16; n++) begin
      rnd = dec ? 15 - n : n;
      exp_q.push_back({(n == 15), 4'(rnd), ref_ks[rnd]});
    end
  endtask

  // Driver: one key, then consume 16 subkeys with ready high pct% of cycles.
  // kill_after>0 aborts (or resets when kill_rst) right after that handshake.
  // noise keeps key_valid high with random keys while the sequence runs.
  task automatic run_seq(input logic [63:0] k, input logic dec, input int pct,
                         input int kill_after, input logic kill_rst, input logic noise);
    int hs;
    int cyc;
    logic [52:0] e;
    build_exp(k, dec);
    check("idle_key_ready", key_ready, 1);
    key = k; decrypt = dec; key_valid = 1'b1; subkey_ready = 1'b0;
    step();
    if (!noise) begin
      key_valid = 1'b0; key = ~k; decrypt = ~dec;
    end
    hs = 0; cyc = 0;
    while (hs < 16 && cyc < 400) begin
      if (noise) begin
        key_valid = 1'b1; key = {$urandom, $urandom}; decrypt = 1'($urandom_range(1));
      end
      subkey_ready = ($urandom_range(99) < pct);
      check("run_key_ready", key_ready, 0);
      check("run_subkey_valid", subkey_valid, 1);
      if (subkey_valid !== 1'b1) break;
      e = exp_q[0];
      check("subkey", subkey, e[47:0]);
      check("subkey_round", subkey_round, e[51:48]);
      check("subkey_last", subkey_last, e[52]);
      if (subkey_ready) begin
        got_ks[hs] = subkey;
        void'(exp_q.pop_front());
        hs++;
      end
      step();
      cyc++;
      if (kill_after > 0 && hs == kill_after) begin
        subkey_ready = 1'b1;
        if (kill_rst) rst_n = 1'b0;
        else abort = 1'b1;
        step();
        rst_n = 1'b1; abort = 1'b0; subkey_ready = 1'b0;
        check("kill_valid", subkey_valid, 0);
        check("kill_key_ready", key_ready, 1);
        check("kill_last", subkey_last, 0);
        if (kill_rst) begin
          check("rst_round", subkey_round, 0);
          check("rst_subkey", subkey, 0);
        end
        exp_q.delete();
        return;
      end
    end
    check("handshakes", hs, 16);
    seq_cycles = cyc;
    key_valid = 1'b0; subkey_ready = 1'b0;
    check("done_key_ready", key_ready, 1);
    check("done_valid", subkey_valid, 0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; seq_cycles = 0;
    rst_n = 1'b0; key_valid = 1'b0; key = '0; decrypt = 1'b0;
    abort = 1'b0; subkey_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    check("reset_key_ready", key_ready, 1);
    check("reset_valid", subkey_valid, 0);
    check("reset_last", subkey_last, 0);
    check("reset_round", subkey_round, 0);
    check("reset_subkey", subkey, 0);

    // FIPS vector, encrypt, no backpressure
    run_seq(FIPS_KEY, 1'b0, 100, 0, 1'b0, 1'b0);
    check("enc_cycles", seq_cycles, 16);
    check("enc_k1", got_ks[0], FIPS_K1);
    check("enc_k2", got_ks[1], FIPS_K2);
    check("enc_k16", got_ks[15], FIPS_K16);

    // FIPS vector, decrypt
    run_seq(FIPS_KEY, 1'b1, 100, 0, 1'b0, 1'b0);
    check("dec_first", got_ks[0], FIPS_K16);
    check("dec_second", got_ks[1], ref_ks[14]);
    check("dec_last", got_ks[15], FIPS_K1);

    // Backpressure, ~30% ready
    run_seq(FIPS_KEY, 1'b0, 30, 0, 1'b0, 1'b0);
    check("bp_k1", got_ks[0], FIPS_K1);
    check("bp_k16", got_ks[15], FIPS_K16);

    // Abort after the 5th handshake, then abort blocks a key in IDLE
    run_seq(FIPS_KEY, 1'b0, 100, 5, 1'b0, 1'b0);
    abort = 1'b1; key_valid = 1'b1; key = {$urandom, $urandom};
    step();
    check("idle_abort_key_ready", key_ready, 1);
    check("idle_abort_valid", subkey_valid, 0);
    abort = 1'b0; key_valid = 1'b0;
    run_seq(64'h0, 1'b0, 100, 0, 1'b0, 1'b0);
    check("zero_k1", got_ks[0], 0);

    // Reset mid-sequence during a decrypt
    run_seq({$urandom, $urandom}, 1'b1, 60, 7, 1'b1, 1'b0);

    // key_valid held with other keys during RUN
    run_seq(FIPS_KEY, 1'b0, 50, 0, 1'b0, 1'b1);
    check("noise_k1", got_ks[0], FIPS_K1);
    check("noise_k16", got_ks[15], FIPS_K16);

    // Random keys, both directions
    for (int n = 0; n < 100; n++) begin
      run_seq({$urandom, $urandom}, 1'b0, $urandom_range(100, 30), 0, 1'b0, 1'b0);
      run_seq({$urandom, $urandom}, 1'b1, $urandom_range(100, 30), 0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
